id_hazard_ctrl: RTL

Pipeline sequencing controller for the ID stage of the 5-stage word-PC RISC-V core. It keeps a per-register scoreboard of in-flight writes to detect RAW hazards, since no forwarding exists, and stalls PC and IF/ID while they are pending. It squashes the wrong-path fetch after a taken branch or jump, and halts fetch on SYSTEM (ECALL/EBREAK) until resumed. It drives `wist` into the ID stage and the write enables of the PC and IF/ID registers.

---
 rtl/id_hazard_pkg.sv | 41 ++++
 rtl/id_hazard_ctrl_scoreboard.sv | 63 ++++++
 rtl/id_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/id_hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: opcodes, FSM states,
// scoreboard widths and source-operand decode helpers.
package id_hazard_pkg;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned FLUSH_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OP, OP_IMM, LOAD, STORE, BRANCH, JALR: return 1'b1;
            JAL, LUI, AUIPC, SYSTEM:               return 1'b0;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OP, STORE, BRANCH: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_scoreboard.sv
// Per-register in-flight write counters (x1..x31) with one issue port, one
// retire port and two pending read ports for the ID-stage sources.
module hazard_scoreboard
    import id_hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_en,
    input  logic [4:0] issue_addr,
    input  logic       retire_en,
    input  logic [4:0] retire_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       rs1_pending,
    output logic       rs2_pending
);

    logic [31:1][CNT_W-1:0] cnt_q;
    logic [31:1][CNT_W-1:0] cnt_d;

    // A write-through register file makes the last outstanding write visible
    // in the same cycle it retires.
    function automatic logic is_pending(input logic [CNT_W-1:0] cnt, input logic retiring);
        return (cnt != '0) && !(WB_BYPASS && (cnt == CNT_W'(1)) && retiring);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned r = 1; r < 32; r++) begin
            if (issue_en && (issue_addr == r[4:0]) && !(retire_en && (retire_addr == r[4:0]))) begin
                if (cnt_q[r[4:0]] != CNT_MAX) begin
                    cnt_d[r[4:0]] = cnt_q[r[4:0]] + CNT_W'(1);
                end
            end else if (retire_en && (retire_addr == r[4:0]) && !(issue_en && (issue_addr == r[4:0]))) begin
                if (cnt_q[r[4:0]] != '0) begin
                    cnt_d[r[4:0]] = cnt_q[r[4:0]] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        if (rs1_addr != '0) begin
            rs1_pending = is_pending(cnt_q[rs1_addr], retire_en && (retire_addr == rs1_addr));
        end
        if (rs2_addr != '0) begin
            rs2_pending = is_pending(cnt_q[rs2_addr], retire_en && (retire_addr == rs2_addr));
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencing: RAW stall via scoreboard, post-redirect flush and SYSTEM halt.
// Define ID_HAZARD_STATS_EN to add the stall/flush/halt cycle counter ports.
module id_hazard_ctrl
    import id_hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          WB_BYPASS    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        id_wreg,
    input  logic        jump_valid,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_wea,
    input  logic        resume,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        wist,
    output logic        stall,
    output logic        redirect,
    output logic        halted
`ifdef ID_HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] halt_cnt
`endif
);

    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);

    state_e             state_q, state_d;
    logic [FLUSH_W-1:0] fctr_q, fctr_d;
    logic [6:0]         opcode;
    logic [4:0]         rs1, rs2, rd;
    logic               rs1_pend, rs2_pend, src_pending, issue_en;
    logic               unused_inst_bits;

    assign opcode           = id_inst[6:0];
    assign rd               = id_inst[11:7];
    assign rs1              = id_inst[19:15];
    assign rs2              = id_inst[24:20];
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

    hazard_scoreboard #(
        .WB_BYPASS(WB_BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (rd),
        .retire_en  (wb_wea),
        .retire_addr(wb_rd_addr),
        .rs1_addr   (rs1),
        .rs2_addr   (rs2),
        .rs1_pending(rs1_pend),
        .rs2_pending(rs2_pend)
    );

    // Outputs are forced to their reset values combinationally so they respond
    // to an asserted reset without waiting for a clock edge.
    always_comb begin
        src_pending = (uses_rs1(opcode) && rs1_pend) || (uses_rs2(opcode) && rs2_pend);
        state_d     = state_q;
        fctr_d      = fctr_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        wist        = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            case (state_q)
                RUN: begin
                    stall    = id_valid && src_pending;
                    redirect = id_valid && jump_valid && !stall;
                    pc_we    = !stall;
                    ifid_we  = !stall;
                    wist     = !id_valid || stall;
                    if (redirect) begin
                        state_d = FLUSH;
                        fctr_d  = FLUSH_LOAD;
                    end else if (id_valid && !stall && (opcode == SYSTEM)) begin
                        state_d = HALT;
                    end
                end
                FLUSH: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    if ((fctr_q == FLUSH_W'(1)) || (fctr_q == '0)) begin
                        state_d = RUN;
                        fctr_d  = '0;
                    end else begin
                        fctr_d = fctr_q - FLUSH_W'(1);
                    end
                end
                HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        issue_en = id_valid && !wist && !stall && id_wreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fctr_q  <= '0;
        end else begin
            state_q <= state_d;
            fctr_q  <= fctr_d;
        end
    end

`ifdef ID_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] halt_cnt_q, halt_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall);
        flush_cnt_d = flush_cnt_q + 32'(state_q == FLUSH);
        halt_cnt_d  = halt_cnt_q + 32'(state_q == HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            halt_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halt_cnt_q  <= halt_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign halt_cnt  = halt_cnt_q;
`endif

endmodule
